// File: rtl/lsu_rv32_pkg.sv
package lsu_rv32_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    ERR_OK       = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_RANGE    = 2'b10,
    ERR_FUNCT3   = 2'b11
  } err_e;

endpackage

// File: rtl/lsu_align_check.sv
module lsu_align_check
  import lsu_rv32_pkg::*;
#(
  parameter int unsigned AddrWidth = 14
) (
  input  logic [31:0] addr,
  input  logic [2:0]  funct3,
  input  logic        we,
  output err_e        err
);

  logic legal;
  logic misaligned;
  logic out_of_range;

  always_comb begin
    legal        = 1'b0;
    misaligned   = 1'b0;
    out_of_range = |(addr >> AddrWidth);
    if (we) begin
      legal = funct3 inside {F3_SB, F3_SH, F3_SW};
    end else begin
      legal = funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
    end
    case (funct3)
      F3_LH, F3_LHU: misaligned = addr[0];
      F3_LW:         misaligned = |addr[1:0];
      default:       misaligned = 1'b0;
    endcase
    if (!legal) begin
      err = ERR_FUNCT3;
    end else if (misaligned) begin
      err = ERR_MISALIGN;
    end else if (out_of_range) begin
      err = ERR_RANGE;
    end else begin
      err = ERR_OK;
    end
  end

endmodule

// File: rtl/lsu_rv32.sv
module lsu_rv32
  import lsu_rv32_pkg::*;
#(
  parameter int unsigned AddrWidth = 14
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [31:0]          req_addr,
  input  logic [31:0]          req_wdata,
  input  logic                 req_we,
  input  logic [2:0]           req_funct3,
  input  logic [4:0]           req_rd,
  output logic [AddrWidth-1:0] mem_addr,
  output logic [31:0]          mem_wdata,
  output logic                 mem_we,
  output logic [2:0]           mem_funct3,
  input  logic [31:0]          mem_rdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_data,
  output logic [4:0]           rsp_rd,
  output logic                 rsp_is_load,
  output logic [1:0]           rsp_err
);

  state_e               state_q, state_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic                 we_q, we_d;
  logic [2:0]           funct3_q, funct3_d;
  logic [4:0]           rd_q, rd_d;
  err_e                 err_q, err_d;
  logic [31:0]          rdata_q, rdata_d;
  err_e                 req_err;
  logic                 accept;

  lsu_align_check #(.AddrWidth(AddrWidth)) u_align_check (
    .addr   (req_addr),
    .funct3 (req_funct3),
    .we     (req_we),
    .err    (req_err)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    funct3_d  = funct3_q;
    rd_d      = rd_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    req_ready = 1'b0;
    case (state_q)
      ST_IDLE: req_ready = 1'b1;
      ST_ACCESS: begin
        rdata_d = we_q ? '0 : mem_rdata;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          req_ready = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Acceptance overrides the state-local next state, which covers both IDLE and a consumed RESP.
    accept = req_valid && req_ready;
    if (accept) begin
      addr_d   = req_addr[AddrWidth-1:0];
      wdata_d  = req_wdata;
      we_d     = req_we;
      funct3_d = req_funct3;
      rd_d     = req_rd;
      err_d    = req_err;
      rdata_d  = '0;
      state_d  = (req_err == ERR_OK) ? ST_ACCESS : ST_RESP;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      funct3_q <= '0;
      rd_q     <= '0;
      err_q    <= ERR_OK;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      rd_q     <= rd_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign mem_funct3  = funct3_q;
  assign mem_we      = (state_q == ST_ACCESS) && we_q;
  assign rsp_valid   = (state_q == ST_RESP);
  assign rsp_data    = rdata_q;
  assign rsp_rd      = rd_q;
  assign rsp_is_load = ~we_q;
  assign rsp_err     = err_q;

endmodule
